divider_param: RTL
==================

// Module: divider_param
// PURPOSE
// - Parametrised multi-cycle iterative divider for the RV32IMC EX stage (M-extension DIV/DIVU/REM/REMU).
// - Generalises the fixed 32-bit, 1-bit/cycle divider: width XLEN, STEP quotient bits retired per cycle,
//   single-cycle RISC-V corner cases, abort on request drop, and optional quotient/remainder reuse.
// - The core holds div_valid high and stalls on div_running until div_done.
// PARAMETERS
// - XLEN  32  operand/result width; must be a multiple of STEP
// - STEP  1   quotient bits per iteration, 1/2/4; N = XLEN/STEP iteration cycles
// PORTS
// - CLK         in   1     clock; all state updates on the rising edge
// - rst         in   1     synchronous, active-high reset
// - opA         in   XLEN  dividend
// - opB         in   XLEN  divisor
// - div_valid   in   1     level request; opA, opB and div_op are stable while it is high
// - div_op      in   2     0=DIV 1=DIVU 2=REM 3=REMU
// - div_running out  1     stall request = div_valid & ~div_done (combinational)
// - div_done    out  1     1-cycle pulse; DIVout is valid in the same cycle
// - DIVout      out  XLEN  registered result; holds its value until the next completion
// BEHAVIOUR
// - Reset: state=IDLE, DIVout=0, div_done=0, iteration counter=0, reuse entry invalid.
// - States: IDLE -> DIVIDING -> DONE -> IDLE.
//   - IDLE: accept when div_valid=1; latch |opA|, |opB|, signs and div_op; load counter with N.
//   - DIVIDING: each edge performs STEP restoring-division steps and decrements the counter.
//     At counter==1, apply sign fix, register DIVout, go to DONE.
//   - DONE: div_done=1 for one cycle, then IDLE.
//   - div_done rises exactly N edges after the accepting edge (32 for default parameters).
// - Back-to-back operations: during the div_done cycle the requester either updates op/operands
//   or drops div_valid. A request still valid in IDLE is accepted as a new operation.
// - Sign rules (DIV/REM): quotient negated iff the operand signs differ; remainder takes the
//   dividend's sign. DIVU/REMU treat operands as unsigned.
// - Corner cases resolve at the accept edge (IDLE->DONE, div_done one edge later):
//   - opB=0: quotient = all ones; remainder = opA.
//   - Signed overflow (opA=MIN, opB=-1): quotient = MIN; remainder = 0.
// - div_valid low while in DIVIDING: abort; IDLE next edge; no div_done; DIVout unchanged.
// - Changes on opA, opB or div_op after acceptance are ignored; the latched copies are used.
// - rst mid-operation: immediate return to the reset state; no div_done.
// CONFIGURATION
// - DIV_REUSE_EN defined:
//   - Each completed non-aborted operation stores its quotient, remainder, opA, opB and
//     signedness (DIV/REM signed, DIVU/REMU unsigned).
//   - A new request matching opA, opB and signedness takes the IDLE->DONE path with the stored
//     result: div_done one edge after acceptance.
//   - The stored entry is invalidated by rst or by an abort.
// - DIV_REUSE_EN undefined: no storage; every operation takes the full or corner-case latency.
// STRUCTURE
// - Package div_pkg: div_op encodings (DIV, DIVU, REM, REMU) and div_state_t (IDLE, DIVIDING, DONE).
// - Sub-module div_iter_stage: combinational STEP-bit restoring stage, parametrised by XLEN and STEP;
//   takes {rem, quo, divisor} and returns the updated {rem, quo}.
// - Top level holds the FSM, counter, sign handling, corner-case detection and the optional reuse entry.
// TESTING
// - opA=100, opB=7, DIV -> DIVout=0x0000000E; div_done 32 edges after acceptance; div_running high until then.
// - opA=0xFFFFFF9C, opB=7:
//   - DIV -> 0xFFFFFFF2; REM -> 0xFFFFFFFE; DIVU -> 0x24924916; REMU -> 0x00000002.
// - opA=0x12345678, opB=0:
//   - DIV -> 0xFFFFFFFF; REMU -> 0x12345678; div_done one edge after acceptance.
// - opA=0x80000000, opB=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0x00000000; one-edge latency.
// - Abort: div_valid dropped at iteration 10 -> IDLE next edge; no div_done; DIVout unchanged.
//   rst at iteration 10 -> all outputs 0.
// - DIV_REUSE_EN: DIV then REM on 100/7 -> REM=2 one edge after acceptance.
//   Then DIVU on 100/7 -> full 32 edges (signedness differs).
//   Without the macro: 32 edges each.
// - STEP=2, opA=100, opB=7, DIV -> 0x0000000E after 16 edges.

Source files
------------

// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider.
// Operation codes, FSM states and small decode helpers.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDING,
    DONE
  } div_state_t;

  function automatic logic op_signed(
    input logic [1:0] op
  );
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(
    input logic [1:0] op
  );
    return op[1];
  endfunction

endpackage

// File: rtl/div_iter_stage.sv
// Combinational restoring-division stage.
// Retires STEP quotient bits per call.
module div_iter_stage #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   r;
  logic [XLEN-1:0] q;

  // quo_i holds the not-yet-consumed dividend bits, MSB first
  always_comb begin
    r = {1'b0, rem_i};
    q = quo_i;
    for (int i = 0; i < STEP; i++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, dvsr_i}) begin
        r = r - {1'b0, dvsr_i};
        q[0] = 1'b1;
      end
    end
    rem_o = r[XLEN-1:0];
    quo_o = q;
  end

endmodule

// File: rtl/divider_param.sv
// Parametrised multi-cycle RISC-V divider (DIV/DIVU/REM/REMU).
// Define DIV_REUSE_EN to keep the last result for back-to-back reuse.
module divider_param
  import div_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            div_valid,
  input  logic [1:0]      div_op,
  output logic            div_running,
  output logic            div_done,
  output logic [XLEN-1:0] DIVout
);

  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic [XLEN-1:0] rem_n, quo_n;
  logic            neg_q, neg_r, rem_sel;

  logic            sgn, a_neg, b_neg;
  logic            b_zero, ovf, hit;
  logic            accept, corner;
  logic            finish, abort;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] cq, cr, hq, hr;
  logic [XLEN-1:0] q_fix, r_fix;

  assign sgn    = op_signed(div_op);
  assign a_neg  = sgn & opA[XLEN-1];
  assign b_neg  = sgn & opB[XLEN-1];
  assign a_abs  = a_neg ? -opA : opA;
  assign b_abs  = b_neg ? -opB : opB;
  assign b_zero = (opB == '0);
  assign ovf    = sgn & (opA == MIN)
                & (opB == '1);
  assign cq     = b_zero ? '1 : MIN;
  assign cr     = b_zero ? opA : '0;

  assign accept = (state == IDLE) & div_valid;
  assign corner = accept & (b_zero | ovf);
  assign finish = (state == DIVIDING)
                & div_valid
                & (cnt == CW'(1));
  assign abort  = (state == DIVIDING)
                & ~div_valid;

  assign q_fix = neg_q ? -quo_n : quo_n;
  assign r_fix = neg_r ? -rem_n : rem_n;

  assign div_running = div_valid & ~div_done;

  div_iter_stage #(
    .XLEN(XLEN),
    .STEP(STEP)
  ) u_iter (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvsr_i(dvsr_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

`ifdef DIV_REUSE_EN
  logic            rv_vld, rv_sgn, lat_sgn;
  logic [XLEN-1:0] rv_a, rv_b, rv_q, rv_r;
  logic [XLEN-1:0] lat_a, lat_b;

  assign hit = accept & rv_vld
             & (opA == rv_a)
             & (opB == rv_b)
             & (sgn == rv_sgn);
  assign hq  = rv_q;
  assign hr  = rv_r;

  always_ff @(posedge CLK) begin
    if (rst) begin
      rv_vld  <= 1'b0;
      rv_sgn  <= 1'b0;
      rv_a    <= '0;
      rv_b    <= '0;
      rv_q    <= '0;
      rv_r    <= '0;
      lat_sgn <= 1'b0;
      lat_a   <= '0;
      lat_b   <= '0;
    end else begin
      if (accept) begin
        lat_a   <= opA;
        lat_b   <= opB;
        lat_sgn <= sgn;
      end
      if (abort) begin
        rv_vld <= 1'b0;
      end else if (corner) begin
        rv_vld <= 1'b1;
        rv_a   <= opA;
        rv_b   <= opB;
        rv_sgn <= sgn;
        rv_q   <= cq;
        rv_r   <= cr;
      end else if (finish) begin
        rv_vld <= 1'b1;
        rv_a   <= lat_a;
        rv_b   <= lat_b;
        rv_sgn <= lat_sgn;
        rv_q   <= q_fix;
        rv_r   <= r_fix;
      end
    end
  end
`else
  assign hit = 1'b0;
  assign hq  = '0;
  assign hr  = '0;
`endif

  // Short paths enter DONE with div_done low; it rises on the next edge
  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rem_sel  <= 1'b0;
      div_done <= 1'b0;
      DIVout   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div_valid) begin
            rem_sel <= op_is_rem(div_op);
            if (corner) begin
              DIVout <= op_is_rem(div_op)
                      ? cr : cq;
              state  <= DONE;
            end else if (hit) begin
              DIVout <= op_is_rem(div_op)
                      ? hr : hq;
              state  <= DONE;
            end else begin
              rem_q  <= '0;
              quo_q  <= a_abs;
              dvsr_q <= b_abs;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              cnt    <= CW'(N);
              state  <= DIVIDING;
            end
          end
        end
        DIVIDING: begin
          if (!div_valid) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt   <= cnt - CW'(1);
            if (finish) begin
              DIVout   <= rem_sel
                        ? r_fix : q_fix;
              div_done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          if (div_done) begin
            div_done <= 1'b0;
            state    <= IDLE;
          end else begin
            div_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
